// File: rtl/mem_page_reader.sv
// Read side of the BX-paged input memory: each BX start opens the page written in the
// previous BX and streams its entries out. Optional MEM_READER_STATS_EN adds trunc_count.
module mem_page_reader #(
  parameter int unsigned DATA_WIDTH  = 18,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned TMUX        = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            start,
  output logic [1:0]            done,
  input  logic [5:0]            number_in,
  output logic [ADDR_WIDTH-1:0] read_add,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [2:0]            bx_out,
  output logic                  truncated
`ifdef MEM_READER_STATS_EN
  ,
  output logic [15:0]           trunc_count
`endif
);

  localparam int unsigned IdxW = ADDR_WIDTH - 1;
  localparam int unsigned MaxN = 1 << IdxW;

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e                state_q, state_d;
  logic [2:0]            bx_q, bx_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d, n_clamp;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] read_add_q, read_add_d;
  logic                  iss_q, iss_d;
  logic [2:0]            iss_bx_q, iss_bx_d;
  logic                  trunc_q, trunc_d;
  logic                  last_issue;
  logic                  clear;

  // start[1] acts as a pipeline reset on everything except the done line and statistics.
  assign clear = reset | start[1];

  assign n_clamp    = (32'(number_in) > MaxN) ? ADDR_WIDTH'(MaxN) : ADDR_WIDTH'(number_in);
  assign last_issue = ({1'b0, idx_q} == n_q - ADDR_WIDTH'(1));

  always_comb begin
    state_d    = state_q;
    bx_d       = bx_q;
    n_d        = n_q;
    idx_d      = idx_q;
    read_add_d = read_add_q;
    iss_d      = 1'b0;
    iss_bx_d   = iss_bx_q;
    trunc_d    = 1'b0;

    if (start[0]) begin
      // A new BX takes priority over any issue still pending from the old one.
      bx_d    = bx_q + 3'd1;
      n_d     = n_clamp;
      idx_d   = '0;
      state_d = (n_clamp == '0) ? StIdle : StRead;
      trunc_d = (state_q == StRead);
    end else if (state_q == StRead) begin
      read_add_d = {bx_q[0], idx_q};
      iss_d      = 1'b1;
      iss_bx_d   = bx_q;
      idx_d      = idx_q + 1'b1;
      if (last_issue) begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= StIdle;
      bx_q       <= 3'b111;
      n_q        <= '0;
      idx_q      <= '0;
      read_add_q <= '0;
      iss_q      <= 1'b0;
      iss_bx_q   <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      bx_q       <= bx_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      read_add_q <= read_add_d;
      iss_q      <= iss_d;
      iss_bx_q   <= iss_bx_d;
      trunc_q    <= trunc_d;
    end
  end

  // Issue flag and BX tag travel alongside the memory read latency.
  logic [MEM_LATENCY-1:0] iss_pipe_q;
  logic [2:0]             bx_pipe_q [MEM_LATENCY];

  always_ff @(posedge clk) begin
    if (clear) begin
      iss_pipe_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        bx_pipe_q[i] <= '0;
      end
    end else begin
      iss_pipe_q[0] <= iss_q;
      bx_pipe_q[0]  <= iss_bx_q;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        iss_pipe_q[i] <= iss_pipe_q[i-1];
        bx_pipe_q[i]  <= bx_pipe_q[i-1];
      end
    end
  end

  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic [2:0]            bx_out_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      data_q   <= '0;
      valid_q  <= 1'b0;
      bx_out_q <= '0;
    end else begin
      valid_q <= iss_pipe_q[MEM_LATENCY-1];
      if (iss_pipe_q[MEM_LATENCY-1]) begin
        data_q   <= data_in;
        bx_out_q <= bx_pipe_q[MEM_LATENCY-1];
      end
    end
  end

  logic [1:0] done_q [TMUX];

  // A pipeline reset flushes the done line but still propagates itself downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TMUX; i++) begin
        done_q[i] <= '0;
      end
    end else if (start[1]) begin
      done_q[0] <= start;
      for (int i = 1; i < TMUX; i++) begin
        done_q[i] <= '0;
      end
    end else begin
      done_q[0] <= start;
      for (int i = 1; i < TMUX; i++) begin
        done_q[i] <= done_q[i-1];
      end
    end
  end

`ifdef MEM_READER_STATS_EN
  logic [ADDR_WIDTH-1:0] drop;
  logic [16:0]           cnt_sum;
  logic [15:0]           cnt_q;

  assign drop    = n_q - {1'b0, idx_q};
  assign cnt_sum = {1'b0, cnt_q} + 17'(drop);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (trunc_d && !start[1]) begin
      cnt_q <= cnt_sum[16] ? 16'hffff : cnt_sum[15:0];
    end
  end

  assign trunc_count = cnt_q;
`endif

  assign read_add  = read_add_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign bx_out    = bx_out_q;
  assign truncated = trunc_q;
  assign done      = done_q[TMUX-1];

endmodule

// File: tb/tb_mem_page_reader.sv
// Directed bench for mem_page_reader: cycle-trace vector table plus hand-written
// sequences for saturation, truncation, mid-stream reset and pipeline reset.
module tb_mem_page_reader;

  localparam int DW = 18;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    start;
  logic [1:0]    done;
  logic [5:0]    number_in;
  logic [AW-1:0] read_add;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [2:0]    bx_out;
  logic          truncated;
`ifdef MEM_READER_STATS_EN
  logic [15:0]   trunc_count;
`endif

  always #5 clk = ~clk;

  mem_page_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_LATENCY(2),
    .TMUX       (6)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .number_in(number_in),
    .read_add (read_add),
    .data_in  (data_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .bx_out   (bx_out),
    .truncated(truncated)
`ifdef MEM_READER_STATS_EN
    ,
    .trunc_count(trunc_count)
`endif
  );

  function automatic logic [DW-1:0] word(input logic [AW-1:0] a);
    return {12'hA5C, a};
  endfunction

  // Two-register memory model.
  logic [DW-1:0] m1;
  always @(posedge clk) begin
    m1      <= word(read_add);
    data_in <= m1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst;
    logic [1:0]    st;
    logic [5:0]    num;
    logic [AW-1:0] ra;
    logic          v;
    logic [DW-1:0] d;
    logic [2:0]    bx;
    logic          tr;
  } vec_t;

  function automatic vec_t mkv(input logic rst, input logic [1:0] st, input logic [5:0] num,
                               input logic [AW-1:0] ra, input logic v, input logic [DW-1:0] d,
                               input logic [2:0] bx);
    vec_t r;
    r.rst = rst; r.st = st; r.num = num; r.ra = ra; r.v = v; r.d = d; r.bx = bx; r.tr = 1'b0;
    return r;
  endfunction

  vec_t vecs[26];

  initial begin
    int vcnt;
    int tcnt;
    logic [DW-1:0] last_d;
    logic [2:0] last_bx;

    // Test 1: five entries from page 0; then test 2: two BXs, second on page 1.
    vecs[0]  = mkv(1, 2'b00, 0, 0,  0, 0,        0);
    vecs[1]  = mkv(0, 2'b01, 5, 0,  0, 0,        0);
    vecs[2]  = mkv(0, 2'b00, 0, 0,  0, 0,        0);
    vecs[3]  = mkv(0, 2'b00, 0, 1,  0, 0,        0);
    vecs[4]  = mkv(0, 2'b00, 0, 2,  0, 0,        0);
    vecs[5]  = mkv(0, 2'b00, 0, 3,  1, word(0),  0);
    vecs[6]  = mkv(0, 2'b00, 0, 4,  1, word(1),  0);
    vecs[7]  = mkv(0, 2'b00, 0, 4,  1, word(2),  0);
    vecs[8]  = mkv(0, 2'b00, 0, 4,  1, word(3),  0);
    vecs[9]  = mkv(0, 2'b00, 0, 4,  1, word(4),  0);
    vecs[10] = mkv(0, 2'b00, 0, 4,  0, word(4),  0);
    vecs[11] = mkv(0, 2'b00, 0, 4,  0, word(4),  0);
    vecs[12] = mkv(1, 2'b00, 0, 0,  0, 0,        0);
    vecs[13] = mkv(0, 2'b01, 3, 0,  0, 0,        0);
    vecs[14] = mkv(0, 2'b00, 0, 0,  0, 0,        0);
    vecs[15] = mkv(0, 2'b00, 0, 1,  0, 0,        0);
    vecs[16] = mkv(0, 2'b00, 0, 2,  0, 0,        0);
    vecs[17] = mkv(0, 2'b00, 0, 2,  1, word(0),  0);
    vecs[18] = mkv(0, 2'b00, 0, 2,  1, word(1),  0);
    vecs[19] = mkv(0, 2'b01, 2, 2,  1, word(2),  0);
    vecs[20] = mkv(0, 2'b00, 0, 32, 0, word(2),  0);
    vecs[21] = mkv(0, 2'b00, 0, 33, 0, word(2),  0);
    vecs[22] = mkv(0, 2'b00, 0, 33, 0, word(2),  0);
    vecs[23] = mkv(0, 2'b00, 0, 33, 1, word(32), 1);
    vecs[24] = mkv(0, 2'b00, 0, 33, 1, word(33), 1);
    vecs[25] = mkv(0, 2'b00, 0, 33, 0, word(33), 1);

    for (int i = 0; i < 26; i++) begin
      reset     = vecs[i].rst;
      start     = vecs[i].st;
      number_in = vecs[i].num;
      tick();
      check($sformatf("vec%0d read_add", i), 32'(read_add), 32'(vecs[i].ra));
      check($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].v));
      check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].d));
      check($sformatf("vec%0d bx_out", i), 32'(bx_out), 32'(vecs[i].bx));
      check($sformatf("vec%0d truncated", i), 32'(truncated), 32'(vecs[i].tr));
    end

    // Test 3: empty page, read_add holds, done[0] six clocks after start[0].
    reset = 0; start = 2'b01; number_in = 0;
    tick();
    start = 2'b00;
    check("t3 done k0", 32'(done), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check($sformatf("t3 done k%0d", k), 32'(done), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("t3 valid k%0d", k), 32'(valid_out), 32'd0);
      check($sformatf("t3 read_add k%0d", k), 32'(read_add), 32'd33);
    end

    // Test 4a: number_in above the page size saturates to 32 entries.
    reset = 1; tick(); reset = 0;
    start = 2'b01; number_in = 63; tick(); start = 2'b00;
    vcnt = 0; last_d = '0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (valid_out) begin
        vcnt++;
        last_d = data_out;
      end
    end
    check("t4a valid count", 32'(vcnt), 32'd32);
    check("t4a last read_add", 32'(read_add), 32'd31);
    check("t4a last data", 32'(last_d), 32'(word(31)));

    // Test 4b: 40 saturates to 32; new BX after 10 issues truncates 22 entries.
    reset = 1; tick(); reset = 0;
    start = 2'b01; number_in = 40; tick();
    vcnt = 0; tcnt = 0; last_d = '0; last_bx = '0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 11) begin
        start = 2'b01; number_in = 1;
      end else begin
        start = 2'b00;
      end
      tick();
      vcnt += int'(valid_out);
      tcnt += int'(truncated);
      if (valid_out) begin
        last_d  = data_out;
        last_bx = bx_out;
      end
      if (k == 10) check("t4b read_add before cut", 32'(read_add), 32'd9);
      if (k == 11) begin
        check("t4b truncated pulse", 32'(truncated), 32'd1);
        check("t4b read_add at cut", 32'(read_add), 32'd9);
`ifdef MEM_READER_STATS_EN
        check("t4b trunc_count", 32'(trunc_count), 32'd22);
`endif
      end
      if (k == 12) begin
        check("t4b truncated end", 32'(truncated), 32'd0);
        check("t4b new page addr", 32'(read_add), 32'd32);
      end
    end
    check("t4b valid count", 32'(vcnt), 32'd11);
    check("t4b truncated count", 32'(tcnt), 32'd1);
    check("t4b last data", 32'(last_d), 32'(word(32)));
    check("t4b last bx", 32'(last_bx), 32'd1);

    // Test 5: reset mid-stream (with start[0] also high) discards in-flight words.
    reset = 1; tick(); reset = 0;
    start = 2'b01; number_in = 7; tick(); start = 2'b00;
    tick(); tick();
    check("t5 read_add before reset", 32'(read_add), 32'd1);
    reset = 1; start = 2'b01; number_in = 3; tick();
    reset = 0; start = 2'b00;
    check("t5 valid after reset", 32'(valid_out), 32'd0);
    check("t5 read_add after reset", 32'(read_add), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t5 quiet valid k%0d", k), 32'(valid_out), 32'd0);
      check($sformatf("t5 quiet read_add k%0d", k), 32'(read_add), 32'd0);
    end
    start = 2'b01; number_in = 2; tick(); start = 2'b00;
    vcnt = 0; last_d = '0; last_bx = 3'd7;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) check("t5 page0 addr", 32'(read_add), 32'd1);
      if (valid_out) begin
        vcnt++;
        last_d  = data_out;
        last_bx = bx_out;
      end
    end
    check("t5 valid count", 32'(vcnt), 32'd2);
    check("t5 last data", 32'(last_d), 32'(word(1)));
    check("t5 bx", 32'(last_bx), 32'd0);

    // Test 6: start[1] together with start[0] resets the BX counter, no stream.
    start = 2'b11; number_in = 5; tick(); start = 2'b00;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("t6 quiet valid k%0d", k), 32'(valid_out), 32'd0);
      check($sformatf("t6 quiet read_add k%0d", k), 32'(read_add), 32'd0);
    end
    start = 2'b01; number_in = 2; tick(); start = 2'b00;
    vcnt = 0; last_bx = 3'd7;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) check("t6 page0 addr", 32'(read_add), 32'd1);
      if (valid_out) begin
        vcnt++;
        last_bx = bx_out;
      end
    end
    check("t6 valid count", 32'(vcnt), 32'd2);
    check("t6 bx", 32'(last_bx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_page_reader.md
Name: mem_page_reader

Overview:
- Read-side companion of the BX-paged input memory.
- On each BX start, reads the page written during the previous BX and streams the entries out as a valid-qualified word stream, one word per clock.
- Generates read_add using the page's entry count (number_in).
- Sits between an input memory and the first processing stage (e.g. tracklet engine input).

Parameters:
- DATA_WIDTH, 18, width of memory words.
- ADDR_WIDTH, 6, read address width; MSB is the page bit, low ADDR_WIDTH-1 bits are the entry index (max 2^(ADDR_WIDTH-1) entries per page).
- MEM_LATENCY, 2, clocks from read_add to valid data_in (2 for HIGH_PERFORMANCE reg_array).
- TMUX, 6, start-to-done delay in clocks.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  2  [0] new-BX pulse, [1] pipeline reset (same effect as reset on FSM/BX counter).
- done  out  2  start delayed by TMUX clocks.
- number_in  in  6  entry count of the page being opened; sampled on start[0].
- read_add  out  ADDR_WIDTH  memory read address {page, index}.
- data_in  in  DATA_WIDTH  memory read data.
- data_out  out  DATA_WIDTH  streamed entry.
- valid_out  out  1  data_out valid.
- bx_out  out  3  BX tag of data_out.
- truncated  out  1  one-cycle pulse: previous BX's read was cut short.

Behaviour:
- Reset (reset or start[1]):
  - bx counter = 3'b111; FSM = IDLE.
  - read_add = 0, data_out = 0, valid_out = 0, bx_out = 0, truncated = 0.
  - Issue pipeline and done pipeline cleared.
- BX counter: increments on start[0] (first BX after reset reads as 0); page = bx[0] after the increment.
- FSM states IDLE, READ.
  - On start[0], latch n = min(number_in, 2^(ADDR_WIDTH-1)) and set idx = 0.
    - n = 0: go to IDLE.
    - otherwise: go to READ.
  - READ, each clock:
    - read_add <= {page, idx[ADDR_WIDTH-2:0]}; issue flag = 1; idx++.
    - When idx == n-1 is issued, go to IDLE.
  - IDLE: issue flag = 0; read_add holds its last value.
  - start[0] while in READ (entries remaining): the remaining entries are dropped; truncated pulses 1 on the next clock; the new BX starts in that same cycle (new page, new n, idx = 0).
- Latency:
  - read_add registered; issue flag and bx tag delayed MEM_LATENCY clocks alongside the memory.
  - data_out/valid_out/bx_out registered once more: the word addressed at cycle t appears at t+MEM_LATENCY+1.
  - No gaps within a BX stream.
- Widths:
  - number_in values above 2^(ADDR_WIDTH-1) saturate.
  - idx is ADDR_WIDTH-1 bits; never wraps because of the clamp.
- done: shift register of start, TMUX deep, cleared by reset.
- start[0] and reset in the same cycle: reset wins.
- Reset mid-stream: in-flight words are discarded and valid_out is 0 from the next clock.
- data_out holds its last value when valid_out = 0.

Optional Feature:
- Macro: MEM_READER_STATS_EN.
- Defined: adds output trunc_count[15:0], a saturating count of dropped entries (n - idx at truncation time). Cleared by reset, not by start[1].
- Undefined: port and counter absent; all other behaviour unchanged.

Test Plan:
1. reset, then start[0] with number_in=5 -> read_add = 0,1,2,3,4 on consecutive clocks (page 0); valid_out high 5 clocks starting 3 clocks after the first address; bx_out = 0.
2. Two BXs: number_in=3, then number_in=2 after 6 clocks -> second stream addresses 32,33 (page 1); bx_out = 1; truncated stays 0.
3. number_in=0 -> no valid_out; read_add unchanged; done[0] pulses TMUX=6 clocks after start[0].
4. number_in=40 with ADDR_WIDTH=6 -> saturates to 32 entries; start[0] again after 10 clocks -> truncated pulses once; with MEM_READER_STATS_EN, trunc_count = 22.
5. reset asserted mid-stream after 2 issues with 5 pending -> valid_out = 0 next clock; next start[0] yields bx_out = 0 and page 0.
6. start[1] asserted with start[0] -> bx counter returns to 3'b111 and no stream starts; the following start[0] reads page 0.
